// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - register file read/write/debug port bundle
interface register_file_if;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic [4:0]  regNo;
  logic [31:0] val;

  modport master (
    output Read1, Read2, WriteReg, WriteData, RegWrite, regNo,
    input  Data1, Data2, val
  );

  modport slave (
    input  Read1, Read2, WriteReg, WriteData, RegWrite, regNo,
    output Data1, Data2, val
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two ALU read ports, one write port, debug read port
module register_file (
  input  logic                  clk,
  input  logic                  startin,
  register_file_if.slave        rf
);

  logic [31:0] r_regs [0:31];

  logic [31:0] w_data1;
  logic [31:0] w_data2;
  logic [31:0] w_val;

  // Reset wins over a same-cycle write; address 0 never stores anything.
  always_ff @(posedge clk) begin
    if (startin) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if (rf.RegWrite && (rf.WriteReg != 5'd0)) begin
      r_regs[rf.WriteReg] <= rf.WriteData;
    end
  end

  // Address 0 is forced to zero on the read side so it reads 0 even before the first reset.
  always_comb begin
    w_data1 = (rf.Read1 == 5'd0) ? 32'h0000_0000 : r_regs[rf.Read1];
    w_data2 = (rf.Read2 == 5'd0) ? 32'h0000_0000 : r_regs[rf.Read2];
    w_val   = (rf.regNo == 5'd0) ? 32'h0000_0000 : r_regs[rf.regNo];
  end

  assign rf.Data1 = w_data1;
  assign rf.Data2 = w_data2;
  assign rf.val   = w_val;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - randomized scoreboard bench for register_file
module tb_register_file;

  logic clk;
  logic startin;

  register_file_if rf ();

  register_file dut (
    .clk     (clk),
    .startin (startin),
    .rf      (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] v;
    bit          k1;
    bit          k2;
    bit          kv;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  bit          known [32];
  int          n_vec;
  int          n_bad;
  int          n_issued;

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  function automatic bit model_known(input logic [4:0] a);
    if (a == 5'd0) return 1'b1;
    return known[a];
  endfunction

  // One cycle of stimulus: drive, record what reads must show before the edge, then apply the edge to the model.
  task automatic cyc(input bit st, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rn);
    exp_t e;
    @(posedge clk);
    #1;
    startin      = st;
    rf.RegWrite  = we;
    rf.WriteReg  = wr;
    rf.WriteData = wd;
    rf.Read1     = r1;
    rf.Read2     = r2;
    rf.regNo     = rn;
    e.idx = n_issued;
    e.d1  = model_rd(r1);
    e.d2  = model_rd(r2);
    e.v   = model_rd(rn);
    e.k1  = model_known(r1);
    e.k2  = model_known(r2);
    e.kv  = model_known(rn);
    sb_q.push_back(e);
    n_issued++;
    if (st) begin
      for (int i = 0; i < 32; i++) begin
        model[i] = 32'h0;
        known[i] = 1'b1;
      end
    end else if (we && wr != 5'd0) begin
      model[wr] = wd;
      known[wr] = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.k1) begin
          n_vec++;
          if (rf.Data1 !== e.d1) begin
            n_bad++;
            $display("FAIL data1 vec %0d: got %h expected %h", e.idx, rf.Data1, e.d1);
          end
        end
        if (e.k2) begin
          n_vec++;
          if (rf.Data2 !== e.d2) begin
            n_bad++;
            $display("FAIL data2 vec %0d: got %h expected %h", e.idx, rf.Data2, e.d2);
          end
        end
        if (e.kv) begin
          n_vec++;
          if (rf.val !== e.v) begin
            n_bad++;
            $display("FAIL val vec %0d: got %h expected %h", e.idx, rf.val, e.v);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] wr;
    n_vec    = 0;
    n_bad    = 0;
    n_issued = 0;
    for (int i = 0; i < 32; i++) begin
      known[i] = (i == 0);
      model[i] = 32'h0;
    end
    startin      = 1'b0;
    rf.RegWrite  = 1'b0;
    rf.WriteReg  = 5'd0;
    rf.WriteData = 32'h0;
    rf.Read1     = 5'd0;
    rf.Read2     = 5'd0;
    rf.regNo     = 5'd0;

    cyc(1, 0, 5'd0, 32'h0,          5'd5,  5'd31, 5'd17);
    cyc(0, 0, 5'd0, 32'h0,          5'd5,  5'd31, 5'd17);
    cyc(0, 1, 5'd1, 32'hAAAA_AAAA,  5'd1,  5'd0,  5'd0);
    cyc(0, 1, 5'd2, 32'h5555_5555,  5'd1,  5'd2,  5'd1);
    cyc(0, 0, 5'd0, 32'h0,          5'd1,  5'd2,  5'd2);
    cyc(0, 1, 5'd0, 32'hFFFF_FFFF,  5'd0,  5'd0,  5'd0);
    cyc(0, 0, 5'd0, 32'h0,          5'd0,  5'd0,  5'd0);
    cyc(0, 0, 5'd1, 32'h1234_5678,  5'd1,  5'd1,  5'd1);
    cyc(0, 1, 5'd1, 32'h1234_5678,  5'd1,  5'd2,  5'd1);
    cyc(0, 0, 5'd0, 32'h0,          5'd1,  5'd2,  5'd1);
    cyc(1, 1, 5'd3, 32'hDEAD_BEEF,  5'd3,  5'd1,  5'd2);
    cyc(0, 0, 5'd0, 32'h0,          5'd3,  5'd1,  5'd2);

    for (int n = 0; n < 600; n++) begin
      wr = 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          wr,
          $urandom,
          ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
          ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
    end
    for (int r = 0; r < 32; r++) begin
      cyc(0, 0, 5'd0, 32'h0, 5'(r), 5'(31 - r), 5'(r));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file for the single-cycle CPU datapath.
- Two combinational read ports feed the ALU operands.
- One synchronous write port takes the writeback result.
- A third combinational debug read port (`regNo`/`val`) lets benches and top-level observers inspect any register.
- Register 0 is hardwired to zero, MIPS-style.

## Interface
Parameters: none. Fixed: 32 registers, 32-bit data, 5-bit addresses.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `startin`  in  1  reset, synchronous, active-high.
- `Read1`  in  5  address, read port 1.
- `Read2`  in  5  address, read port 2.
- `WriteReg`  in  5  write address.
- `WriteData`  in  32  write data.
- `RegWrite`  in  1  write enable, active-high.
- `Data1`  out  32  contents of `regs[Read1]`.
- `Data2`  out  32  contents of `regs[Read2]`.
- `regNo`  in  5  debug read address.
- `val`  out  32  contents of `regs[regNo]`.

## Operation
- Storage: 32 registers × 32 bits, `regs[0..31]`.
- Reset: on a rising `clk` with `startin`=1, all 32 registers clear to 32'h0000_0000.
  - Reset has priority over a write in the same cycle; the write is discarded.
- Write: on a rising `clk` with `startin`=0, `RegWrite`=1 and `WriteReg`≠0, `regs[WriteReg]` ← `WriteData`.
  - `RegWrite`=0: no register changes.
- Register 0:
  - Writes with `WriteReg`=0 are ignored.
  - Reads of address 0 on every port return 0 at all times.
- Reads: `Data1`, `Data2` and `val` are purely combinational functions of their address and current register contents.
  - No enable, no latching.
  - All three ports may address the same register simultaneously.
- No write-through bypass:
  - A read of the register being written returns the old value until the rising edge.
  - The new value appears after the edge.
- Before the first reset, contents of registers 1–31 are undefined (X in simulation). Register 0 still reads 0.
- `regNo` left X/undriven: `val` is don't-care.

## Timing
- Write latency: 1 cycle. Data sampled at the rising edge is visible on any read port within the same cycle, after the edge plus combinational delay.
- Read latency: 0 cycles. Output follows an address change combinationally.
- Reset latency: 1 edge. After the first rising edge with `startin`=1, every output reads 0 for any address.
- Reset mid-operation: a pending write in the reset cycle is lost. Earlier writes are cleared on that edge.
- `RegWrite`, `WriteReg` and `WriteData` must be stable around the rising edge. Writes are edge-sampled only; mid-cycle changes have no effect.
- Multiple back-to-back writes to the same or different registers on consecutive edges are all honored; the last write to an address wins.

## Test plan
- Reset: hold `startin`=1 for one rising edge, then `startin`=0. Set `Read1`=5, `Read2`=31, `regNo`=17 → `Data1`=`Data2`=`val`=0.
- Write/read: write 32'hAAAA_AAAA to reg 1 with `RegWrite`=1 for one edge, then `Read1`=1 → `Data1`=32'hAAAA_AAAA.
  - Next, write 32'h5555_5555 to reg 2, then `Read2`=2 → `Data2`=32'h5555_5555.
  - `Data1` remains 32'hAAAA_AAAA.
- Debug port: after the writes above, `regNo`=1 → `val`=32'hAAAA_AAAA; `regNo`=2 → `val`=32'h5555_5555.
- Register 0: write 32'hFFFF_FFFF with `WriteReg`=0 → `Data1`(`Read1`=0)=0 and `val`(`regNo`=0)=0.
- Write-disable and no-bypass:
  - `RegWrite`=0, `WriteReg`=1, `WriteData`=32'h1234_5678 over an edge → reg 1 unchanged.
  - With `RegWrite`=1 and `Read1`=1: before the edge `Data1` shows the old value; after the edge it shows 32'h1234_5678.
- Reset priority: `startin`=1 and `RegWrite`=1 writing 32'hDEAD_BEEF to reg 3 in the same cycle → after the edge, reg 3 reads 0, and regs 1 and 2 read 0.
